milano_mem_arb: RTL and testbench
=================================

MILANO_MEM_ARB -- requirements
Module: milano_mem_arb

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, byte address width on all ports.
REQ-002 Parameter DATA_WIDTH, default 32, data width; byte enables are DATA_WIDTH/8 bits.
REQ-003 clk_i  in  1  sole clock; all state changes on rising edge.
REQ-004 rst_ni  in  1  reset, asynchronous, active-low.
REQ-005 instr_req_i/instr_addr_i  in  1/ADDR_WIDTH  fetch master read request and address.
REQ-006 instr_gnt_o/instr_rvalid_o  out  1/1  fetch grant and response valid.
REQ-007 instr_rdata_o  out  DATA_WIDTH  fetch read data.
REQ-008 data_req_i/data_addr_i/data_we_i/data_be_i/data_wdata_i  in  1/ADDR_WIDTH/1/DATA_WIDTH/8/DATA_WIDTH  LSU master request.
REQ-009 data_gnt_o/data_rvalid_o/data_rdata_o  out  1/1/DATA_WIDTH  LSU grant, response valid, read data.
REQ-010 mem_req_o/mem_addr_o/mem_we_o/mem_be_o/mem_wdata_o  out  1/ADDR_WIDTH/1/DATA_WIDTH/8/DATA_WIDTH  shared memory request.
REQ-011 mem_gnt_i/mem_rvalid_i/mem_rdata_i  in  1/1/DATA_WIDTH  shared memory grant, response valid, read data.

Function
REQ-012 Protocol on every port: request phase completes on the cycle req&&gnt; every granted transfer (read or write) returns exactly one rvalid pulse, at least 1 cycle after grant.
REQ-013 At most one transfer outstanding; FSM states IDLE (none outstanding) and BUSY (one outstanding, owner register holds FETCH or LSU).
REQ-014 can_issue = (state==IDLE) || (state==BUSY && mem_rvalid_i); a new request is issued in the same cycle as the previous response.
REQ-015 mem_req_o = can_issue && (selected master's req); mem_addr/we/be/wdata muxed from selected master; fetch drives we=0, be=all ones, wdata=0.
REQ-016 Arbitration (default): LSU has fixed priority over fetch when both request.
REQ-017 Lock: if mem_req_o=1 and mem_gnt_i=0, selection is frozen next cycle until granted, even if the other master raises req.
REQ-018 If the locked master drops req before grant, lock clears that cycle and arbitration restarts.
REQ-019 x_gnt_o = mem_gnt_i && mem_req_o && (selected==x); never both grants in one cycle.
REQ-020 On grant: state->BUSY, owner<=selected. On rvalid in BUSY without new grant: state->IDLE.
REQ-021 mem_rvalid_i routed only to owner's rvalid_o, same cycle (combinational); mem_rdata_i drives both rdata_o unconditionally.
REQ-022 mem_rvalid_i in IDLE is dropped: neither rvalid_o asserts, state unchanged.
REQ-023 Neither request ever waits more than one transfer when the other master stops requesting; under default mode continuous LSU requests may starve fetch (accepted).

Reset
REQ-024 rst_ni low: state=IDLE, lock cleared, owner=FETCH, round-robin pointer=FETCH, immediately and asynchronously.
REQ-025 Outputs in reset: all gnt/rvalid/mem_req_o=0, mem_addr/we/be/wdata=0.
REQ-026 Reset mid-transfer abandons the outstanding transfer; a late mem_rvalid_i after reset release is dropped per REQ-022.

Configuration
REQ-027 Macro MILANO_ARB_RR_EN defined: round-robin; on tie, master not granted last wins; pointer updates on every accepted grant; first tie after reset goes to LSU.
REQ-028 Macro MILANO_ARB_RR_EN undefined: fixed LSU priority per REQ-016; no pointer register exists.
REQ-029 Lock (REQ-017/018) and all other behaviour identical in both builds.

Verification
REQ-030 Fetch only, addr 0x0000_0100, gnt same cycle, rvalid 1 cycle later with rdata 0xDEADBEEF -> instr_gnt_o 1 cycle, instr_rvalid_o with 0xDEADBEEF, data_rvalid_o stays 0.
REQ-031 Both req same cycle, fetch 0x100, LSU write 0x2000 data 0x1234_5678 be 0xF -> default build grants LSU first, fetch granted on LSU rvalid cycle.
REQ-032 With MILANO_ARB_RR_EN, both masters request continuously for 6 transfers -> grants alternate LSU,FETCH,LSU,FETCH,LSU,FETCH.
REQ-033 Fetch requests, mem_gnt_i held 0 for 3 cycles, LSU raises req at cycle 1 -> mem_addr_o stays 0x100 until grant, fetch granted first.
REQ-034 rst_ni asserted while BUSY, released, then mem_rvalid_i pulse -> no rvalid_o asserts, state IDLE, next fetch request proceeds normally.
REQ-035 mem_rvalid_i pulse in IDLE with no requests -> both rvalid_o remain 0, no grant issued.

Source files
------------

// File: rtl/milano_mem_arb.sv
// Two-master (fetch / LSU) arbiter onto one single-outstanding memory port.
// Define MILANO_ARB_RR_EN for round-robin ties; the default build gives LSU fixed priority.
module milano_mem_arb #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,

  input  logic                    instr_req_i,
  input  logic [ADDR_WIDTH-1:0]   instr_addr_i,
  output logic                    instr_gnt_o,
  output logic                    instr_rvalid_o,
  output logic [DATA_WIDTH-1:0]   instr_rdata_o,

  input  logic                    data_req_i,
  input  logic [ADDR_WIDTH-1:0]   data_addr_i,
  input  logic                    data_we_i,
  input  logic [DATA_WIDTH/8-1:0] data_be_i,
  input  logic [DATA_WIDTH-1:0]   data_wdata_i,
  output logic                    data_gnt_o,
  output logic                    data_rvalid_o,
  output logic [DATA_WIDTH-1:0]   data_rdata_o,

  output logic                    mem_req_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic                    mem_we_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic                    mem_gnt_i,
  input  logic                    mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

  localparam int unsigned BeWidth = DATA_WIDTH / 8;

  typedef enum logic {StIdle, StBusy} state_e;
  typedef enum logic {MstFetch = 1'b0, MstLsu = 1'b1} mst_e;

  state_e state_q, state_d;
  mst_e   owner_q, owner_d;
  logic   lock_q, lock_d;
  mst_e   lock_sel_q, lock_sel_d;
  mst_e   sel, tie_sel;
  logic   sel_req, can_issue, accept;

`ifdef MILANO_ARB_RR_EN
  // Last master granted; the other one wins the next tie.
  mst_e last_q, last_d;

  always_comb begin
    tie_sel = (last_q == MstLsu) ? MstFetch : MstLsu;
    last_d  = accept ? sel : last_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= MstFetch;
    end else begin
      last_q <= last_d;
    end
  end
`else
  always_comb begin
    tie_sel = MstLsu;
  end
`endif

  // A locked selection holds only while its master keeps requesting.
  always_comb begin
    sel = MstFetch;
    if (lock_q && ((lock_sel_q == MstLsu) ? data_req_i : instr_req_i)) begin
      sel = lock_sel_q;
    end else if (data_req_i && instr_req_i) begin
      sel = tie_sel;
    end else if (data_req_i) begin
      sel = MstLsu;
    end else begin
      sel = MstFetch;
    end
  end

  // Gating with rst_ni keeps every output quiet while reset is held.
  assign sel_req   = (sel == MstLsu) ? data_req_i : instr_req_i;
  assign can_issue = rst_ni && ((state_q == StIdle) || mem_rvalid_i);
  assign mem_req_o = can_issue && sel_req;
  assign accept    = mem_req_o && mem_gnt_i;

  always_comb begin
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    if (mem_req_o) begin
      if (sel == MstLsu) begin
        mem_addr_o  = data_addr_i;
        mem_we_o    = data_we_i;
        mem_be_o    = data_be_i;
        mem_wdata_o = data_wdata_i;
      end else begin
        mem_addr_o  = instr_addr_i;
        mem_be_o    = {BeWidth{1'b1}};
      end
    end
  end

  assign instr_gnt_o    = accept && (sel == MstFetch);
  assign data_gnt_o     = accept && (sel == MstLsu);
  assign instr_rvalid_o = (state_q == StBusy) && mem_rvalid_i && (owner_q == MstFetch);
  assign data_rvalid_o  = (state_q == StBusy) && mem_rvalid_i && (owner_q == MstLsu);
  assign instr_rdata_o  = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    lock_d     = mem_req_o && !mem_gnt_i;
    lock_sel_d = sel;
    if (accept) begin
      state_d = StBusy;
      owner_d = sel;
    end else if ((state_q == StBusy) && mem_rvalid_i) begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      owner_q    <= MstFetch;
      lock_q     <= 1'b0;
      lock_sel_q <= MstFetch;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      lock_q     <= lock_d;
      lock_sel_q <= lock_sel_d;
    end
  end

endmodule

// File: tb/tb_milano_mem_arb.sv
// Directed scoreboard bench for milano_mem_arb: stimulus pushes cycle-stamped expected
// grant/response events; a negedge monitor pops and compares whatever the DUT presents.
module tb_milano_mem_arb;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        instr_req_i;
  logic [31:0] instr_addr_i;
  logic        instr_gnt_o, instr_rvalid_o;
  logic [31:0] instr_rdata_o;
  logic        data_req_i;
  logic [31:0] data_addr_i;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_wdata_i;
  logic        data_gnt_o, data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i, mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  milano_mem_arb #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .instr_req_i   (instr_req_i),
    .instr_addr_i  (instr_addr_i),
    .instr_gnt_o   (instr_gnt_o),
    .instr_rvalid_o(instr_rvalid_o),
    .instr_rdata_o (instr_rdata_o),
    .data_req_i    (data_req_i),
    .data_addr_i   (data_addr_i),
    .data_we_i     (data_we_i),
    .data_be_i     (data_be_i),
    .data_wdata_i  (data_wdata_i),
    .data_gnt_o    (data_gnt_o),
    .data_rvalid_o (data_rvalid_o),
    .data_rdata_o  (data_rdata_o),
    .mem_req_o     (mem_req_o),
    .mem_addr_o    (mem_addr_o),
    .mem_we_o      (mem_we_o),
    .mem_be_o      (mem_be_o),
    .mem_wdata_o   (mem_wdata_o),
    .mem_gnt_i     (mem_gnt_i),
    .mem_rvalid_i  (mem_rvalid_i),
    .mem_rdata_i   (mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int          cyc;
    logic        ig, dg, ir, dr;
    logic [31:0] addr;
    logic [31:0] rdata;
  } ev_t;

  ev_t exp_q[$];
  int  cyc   = 0;
  int  total = 0;
  int  bad   = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle();
    instr_req_i  = 1'b0;
    instr_addr_i = '0;
    data_req_i   = 1'b0;
    data_addr_i  = '0;
    data_we_i    = 1'b0;
    data_be_i    = '0;
    data_wdata_i = '0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
  endtask

  task automatic push(input logic ig, input logic dg, input logic ir, input logic dr,
                      input logic [31:0] addr, input logic [31:0] rdata);
    ev_t e;
    e.cyc = cyc; e.ig = ig; e.dg = dg; e.ir = ir; e.dr = dr;
    e.addr = addr; e.rdata = rdata;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic do_reset();
    step();
    idle();
    rst_ni = 1'b0;
    step();
    step();
    rst_ni = 1'b1;
  endtask

  // Monitor: every cycle in which the DUT shows a grant or response must match the queue head.
  initial begin : monitor
    ev_t e;
    logic        any;
    logic [31:0] oaddr, odata;
    forever begin
      @(negedge clk_i);
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        total++;
        bad++;
        $display("FAIL missing_event: got none expected event of cycle %0d", exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
      any = instr_gnt_o | data_gnt_o | instr_rvalid_o | data_rvalid_o;
      if (any) begin
        total++;
        oaddr = (instr_gnt_o | data_gnt_o) ? mem_addr_o : 32'h0;
        odata = instr_rvalid_o ? instr_rdata_o : (data_rvalid_o ? data_rdata_o : 32'h0);
        if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
          bad++;
          $display("FAIL unexpected_event: got ig=%b dg=%b ir=%b dr=%b addr=%h at cycle %0d expected none",
                   instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o, oaddr, cyc);
        end else begin
          e = exp_q.pop_front();
          if (e.ig !== instr_gnt_o || e.dg !== data_gnt_o || e.ir !== instr_rvalid_o ||
              e.dr !== data_rvalid_o || e.addr !== oaddr || e.rdata !== odata) begin
            bad++;
            $display("FAIL event_c%0d: got ig=%b dg=%b ir=%b dr=%b addr=%h rdata=%h expected ig=%b dg=%b ir=%b dr=%b addr=%h rdata=%h",
                     cyc, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o, oaddr, odata,
                     e.ig, e.dg, e.ir, e.dr, e.addr, e.rdata);
          end
        end
      end
    end
  end

  initial begin : stim
    logic w, prev;
    idle();
    rst_ni = 1'b0;
    // Reset values with all inputs active.
    step();
    instr_req_i = 1'b1; instr_addr_i = 32'h100;
    data_req_i = 1'b1; data_addr_i = 32'h2000; data_we_i = 1'b1; data_be_i = 4'hF;
    data_wdata_i = 32'h1234_5678; mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1;
    settle();
    chk("rst_mem_req", {31'b0, mem_req_o}, 32'h0);
    chk("rst_gnts", {30'b0, instr_gnt_o, data_gnt_o}, 32'h0);
    chk("rst_rvalids", {30'b0, instr_rvalid_o, data_rvalid_o}, 32'h0);
    chk("rst_addr", mem_addr_o, 32'h0);
    chk("rst_we_be", {27'b0, mem_we_o, mem_be_o}, 32'h0);
    chk("rst_wdata", mem_wdata_o, 32'h0);
    step();
    idle();
    rst_ni = 1'b1;

    // Single fetch.
    step();
    instr_req_i = 1'b1; instr_addr_i = 32'h100; mem_gnt_i = 1'b1;
    push(1, 0, 0, 0, 32'h100, 32'h0);
    settle();
    chk("fetch_we_be", {27'b0, mem_we_o, mem_be_o}, 32'h0000_000F);
    chk("fetch_wdata", mem_wdata_o, 32'h0);
    step();
    idle();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
    push(0, 0, 1, 0, 32'h0, 32'hDEAD_BEEF);
    settle();
    chk("fetch_no_req_busy", {31'b0, mem_req_o}, 32'h0);
    step();
    idle();

    // Simultaneous requests: LSU write first, fetch issued on the LSU response cycle.
    do_reset();
    step();
    instr_req_i = 1'b1; instr_addr_i = 32'h100;
    data_req_i = 1'b1; data_addr_i = 32'h2000; data_we_i = 1'b1; data_be_i = 4'hF;
    data_wdata_i = 32'h1234_5678; mem_gnt_i = 1'b1;
    push(0, 1, 0, 0, 32'h2000, 32'h0);
    settle();
    chk("lsu_we_be", {27'b0, mem_we_o, mem_be_o}, 32'h0000_001F);
    chk("lsu_wdata", mem_wdata_o, 32'h1234_5678);
    step();
    data_req_i = 1'b0; data_we_i = 1'b0; data_wdata_i = '0;
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0;
    push(1, 0, 0, 1, 32'h100, 32'h0);
    step();
    instr_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rdata_i = 32'hCAFE_0001;
    push(0, 0, 1, 0, 32'h0, 32'hCAFE_0001);
    step();
    idle();

    // Continuous contention over six transfers.
    do_reset();
    prev = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      instr_req_i = 1'b1; instr_addr_i = 32'h100;
      data_req_i = 1'b1; data_addr_i = 32'h2000; data_we_i = 1'b0; data_be_i = 4'hF;
      mem_gnt_i = 1'b1; mem_rvalid_i = (k > 0); mem_rdata_i = (k > 0) ? 32'hA0 + k : 32'h0;
`ifdef MILANO_ARB_RR_EN
      w = (k % 2 == 0);
`else
      w = 1'b1;
`endif
      push(!w, w, (k > 0) && !prev, (k > 0) && prev, w ? 32'h2000 : 32'h100,
           (k > 0) ? 32'hA0 + k : 32'h0);
      prev = w;
    end
    step();
    idle();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hB0;
    push(0, 0, !prev, prev, 32'h0, 32'hB0);
    step();
    idle();

    // Lock: fetch stalled by memory keeps the port although LSU joins.
    do_reset();
    step();
    instr_req_i = 1'b1; instr_addr_i = 32'h100;
    settle();
    chk("lock_addr_c0", mem_addr_o, 32'h100);
    step();
    data_req_i = 1'b1; data_addr_i = 32'h2000; data_be_i = 4'hF;
    settle();
    chk("lock_addr_c1", mem_addr_o, 32'h100);
    step();
    settle();
    chk("lock_addr_c2", mem_addr_o, 32'h100);
    step();
    mem_gnt_i = 1'b1;
    push(1, 0, 0, 0, 32'h100, 32'h0);
    step();
    instr_req_i = 1'b0;
    settle();
    chk("lock_busy_no_req", {31'b0, mem_req_o}, 32'h0);
    step();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h33;
    push(0, 1, 1, 0, 32'h2000, 32'h33);
    step();
    data_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rdata_i = 32'h44;
    push(0, 0, 0, 1, 32'h0, 32'h44);
    step();
    idle();

    // Lock released when the locked master withdraws.
    do_reset();
    step();
    instr_req_i = 1'b1; instr_addr_i = 32'h100;
    step();
    instr_req_i = 1'b0;
    data_req_i = 1'b1; data_addr_i = 32'h2000; data_we_i = 1'b1; data_be_i = 4'h3;
    data_wdata_i = 32'h77; mem_gnt_i = 1'b1;
    push(0, 1, 0, 0, 32'h2000, 32'h0);
    settle();
    chk("unlock_be", {28'b0, mem_be_o}, 32'h3);
    step();
    idle();
    mem_rvalid_i = 1'b1;
    push(0, 0, 0, 1, 32'h0, 32'h0);
    step();
    idle();

    // Reset while busy; the late response is dropped.
    do_reset();
    step();
    instr_req_i = 1'b1; instr_addr_i = 32'h100; mem_gnt_i = 1'b1;
    push(1, 0, 0, 0, 32'h100, 32'h0);
    step();
    idle();
    rst_ni = 1'b0;
    step();
    rst_ni = 1'b1;
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h99;
    settle();
    chk("late_rvalid_dropped", {30'b0, instr_rvalid_o, data_rvalid_o}, 32'h0);
    step();
    idle();
    instr_req_i = 1'b1; instr_addr_i = 32'h300; mem_gnt_i = 1'b1;
    push(1, 0, 0, 0, 32'h300, 32'h0);
    step();
    idle();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h55;
    push(0, 0, 1, 0, 32'h0, 32'h55);
    step();
    idle();

    // Stray response in idle.
    step();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h66;
    settle();
    chk("idle_rvalid_dropped", {30'b0, instr_rvalid_o, data_rvalid_o}, 32'h0);
    chk("idle_no_grant", {29'b0, mem_req_o, instr_gnt_o, data_gnt_o}, 32'h0);
    step();
    idle();

    step();
    step();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
